// File: rtl/hit_judge_if.sv
// Frame-rate bus between the game logic and one hit_judge instance:
// attacker/defender geometry in, kill/clash verdicts out.
interface hit_judge_if #(
  parameter int COORD_W = 12
) ();
  logic               frame_tick;
  logic               atk_lunge;
  logic [COORD_W-1:0] atk_tip_x;
  logic [COORD_W-1:0] atk_tip_y;
  logic [COORD_W-1:0] def_x_l;
  logic [COORD_W-1:0] def_x_r;
  logic [COORD_W-1:0] def_y_t;
  logic [COORD_W-1:0] def_y_b;
  logic               def_guard;
  logic [COORD_W-1:0] def_sword_y;
  logic               def_dead;
  logic               kill;
  logic               clash;
  logic               hit_pending;
  logic [7:0]         kills;

  modport master (
    output frame_tick, atk_lunge, atk_tip_x, atk_tip_y,
           def_x_l, def_x_r, def_y_t, def_y_b, def_guard, def_sword_y, def_dead,
    input  kill, clash, hit_pending, kills
  );

  modport slave (
    input  frame_tick, atk_lunge, atk_tip_x, atk_tip_y,
           def_x_l, def_x_r, def_y_t, def_y_b, def_guard, def_sword_y, def_dead,
    output kill, clash, hit_pending, kills
  );
endinterface

// File: rtl/hit_judge.sv
// Per-frame sword-hit referee: snapshot -> geometry flags -> IDLE/CONFIRM/COOLDOWN
// FSM producing one-cycle kill/clash pulses and a saturating kill counter.
module hit_judge #(
  parameter int COORD_W         = 12,
  parameter int CONFIRM_FRAMES  = 2,
  parameter int CLASH_TOL       = 8,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        round_reset,
  hit_judge_if.slave  bus
);

  localparam logic [3:0]       CONF_TGT    = 4'(CONFIRM_FRAMES);
  localparam logic [7:0]       CD_TGT      = 8'(COOLDOWN_FRAMES);
  localparam logic [COORD_W:0] CLASH_TOL_W = (COORD_W + 1)'(CLASH_TOL);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONFIRM  = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  typedef struct packed {
    logic               lunge;
    logic [COORD_W-1:0] tip_x;
    logic [COORD_W-1:0] tip_y;
    logic [COORD_W-1:0] x_l;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_t;
    logic [COORD_W-1:0] y_b;
    logic               guard;
    logic [COORD_W-1:0] sword_y;
    logic               dead;
  } snap_t;

  typedef struct packed {
    logic overlap;
    logic clash;
    logic dead;
    logic lunge;
  } flags_t;

  snap_t  snap_q,  snap_d;
  logic   v1_q,    v1_d;
  flags_t flags_q, flags_d;
  logic   v2_q,    v2_d;

  state_e     state_q,       state_d;
  logic [3:0] conf_cnt_q,    conf_cnt_d;
  logic [7:0] cd_cnt_q,      cd_cnt_d;
  logic       kill_q,        kill_d;
  logic       clash_q,       clash_d;
  logic       hit_pending_q, hit_pending_d;
  logic [7:0] kills_q,       kills_d;

  logic             in_x, in_y, overlap_c;
  logic [COORD_W:0] tip_e, sword_e, dy;
  logic             take_kill;

  // Stage 0/1: snapshot on frame_tick, then geometry flags from the snapshot.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    v1_d   = bus.frame_tick;
    snap_d = snap_q;
    if (bus.frame_tick) begin
      snap_d = '{lunge:   bus.atk_lunge,
                 tip_x:   bus.atk_tip_x,
                 tip_y:   bus.atk_tip_y,
                 x_l:     bus.def_x_l,
                 x_r:     bus.def_x_r,
                 y_t:     bus.def_y_t,
                 y_b:     bus.def_y_b,
                 guard:   bus.def_guard,
                 sword_y: bus.def_sword_y,
                 dead:    bus.def_dead};
    end

    // An inverted box fails one of the two comparisons and so never overlaps.
    in_x      = (snap_q.x_l <= snap_q.tip_x) && (snap_q.tip_x <= snap_q.x_r);
    in_y      = (snap_q.y_t <= snap_q.tip_y) && (snap_q.tip_y <= snap_q.y_b);
    overlap_c = snap_q.lunge && in_x && in_y;
    tip_e     = {1'b0, snap_q.tip_y};
    sword_e   = {1'b0, snap_q.sword_y};
    dy        = (tip_e >= sword_e) ? (tip_e - sword_e) : (sword_e - tip_e);

    v2_d    = v1_q;
    flags_d = flags_q;
    if (v1_q) begin
      flags_d.overlap = overlap_c;
      flags_d.clash   = overlap_c && snap_q.guard && (dy <= CLASH_TOL_W);
      flags_d.dead    = snap_q.dead;
      flags_d.lunge   = snap_q.lunge;
    end
  end

  // Stage 2: referee FSM, evaluated once per valid frame.
  always_comb begin
    state_d    = state_q;
    conf_cnt_d = conf_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    kill_d     = 1'b0;
    clash_d    = 1'b0;
    kills_d    = kills_q;
    take_kill  = 1'b0;

    if (v2_q) begin
      unique case (state_q)
        IDLE: begin
          if (flags_q.dead) begin
            state_d = IDLE;
          end else if (flags_q.clash) begin
            clash_d  = 1'b1;
            cd_cnt_d = '0;
            state_d  = COOLDOWN;
          end else if (flags_q.overlap) begin
            if (CONF_TGT == 4'd1) begin
              take_kill = 1'b1;
            end else begin
              conf_cnt_d = 4'd1;
              state_d    = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (flags_q.dead || !flags_q.overlap) begin
            conf_cnt_d = '0;
            state_d    = IDLE;
          end else if (flags_q.clash) begin
            clash_d    = 1'b1;
            cd_cnt_d   = '0;
            conf_cnt_d = '0;
            state_d    = COOLDOWN;
          end else if (conf_cnt_q + 4'd1 >= CONF_TGT) begin
            take_kill = 1'b1;
          end else begin
            conf_cnt_d = conf_cnt_q + 4'd1;
          end
        end
        COOLDOWN: begin
          // The attacker must retract after the wait before the judge re-arms.
          if (cd_cnt_q >= CD_TGT && !flags_q.lunge) begin
            state_d = IDLE;
          end else if (cd_cnt_q < CD_TGT) begin
            cd_cnt_d = cd_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (take_kill) begin
        kill_d     = 1'b1;
        kills_d    = (kills_q == 8'hFF) ? kills_q : kills_q + 8'd1;
        cd_cnt_d   = '0;
        conf_cnt_d = '0;
        state_d    = COOLDOWN;
      end
    end

    hit_pending_d = (state_d == CONFIRM);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      snap_q        <= '0;
      v1_q          <= 1'b0;
      flags_q       <= '0;
      v2_q          <= 1'b0;
      state_q       <= IDLE;
      conf_cnt_q    <= '0;
      cd_cnt_q      <= '0;
      kill_q        <= 1'b0;
      clash_q       <= 1'b0;
      hit_pending_q <= 1'b0;
      kills_q       <= '0;
    end else if (round_reset) begin
      snap_q        <= '0;
      v1_q          <= 1'b0;
      flags_q       <= '0;
      v2_q          <= 1'b0;
      state_q       <= IDLE;
      conf_cnt_q    <= '0;
      cd_cnt_q      <= '0;
      kill_q        <= 1'b0;
      clash_q       <= 1'b0;
      hit_pending_q <= 1'b0;
    end else begin
      snap_q        <= snap_d;
      v1_q          <= v1_d;
      flags_q       <= flags_d;
      v2_q          <= v2_d;
      state_q       <= state_d;
      conf_cnt_q    <= conf_cnt_d;
      cd_cnt_q      <= cd_cnt_d;
      kill_q        <= kill_d;
      clash_q       <= clash_d;
      hit_pending_q <= hit_pending_d;
      kills_q       <= kills_d;
    end
  end

  assign bus.kill        = kill_q;
  assign bus.clash       = clash_q;
  assign bus.hit_pending = hit_pending_q;
  assign bus.kills       = kills_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: hand-computed expectations for hit, miss,
// clash, cooldown, blocking, back-to-back and counter saturation cases.
module tb_hit_judge;
  localparam int COORD_W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic round_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hit_judge_if #(.COORD_W(COORD_W)) bus ();

  hit_judge #(
    .COORD_W(COORD_W), .CONFIRM_FRAMES(2), .CLASH_TOL(8), .COOLDOWN_FRAMES(30)
  ) dut (
    .clk(clk), .reset(reset), .round_reset(round_reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // One frame: tick for one cycle, then watch five negedges for pulses.
  task automatic do_frame(output int k, output int c, output int k_at);
    k = 0; c = 0; k_at = -1;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) bus.frame_tick = 1'b0;
      if (bus.kill) begin
        k++;
        if (k_at < 0) k_at = i;
      end
      if (bus.clash) c++;
    end
  endtask

  task automatic set_tip(input int x, input int y);
    bus.atk_tip_x = COORD_W'(x);
    bus.atk_tip_y = COORD_W'(y);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_round_reset();
    @(negedge clk); round_reset = 1'b1;
    @(negedge clk); round_reset = 1'b0;
  endtask

  task automatic test_reset();
    int k, c, at;
    set_tip(100, 200);
    do_frame(k, c, at);
    checks++; if (bus.hit_pending !== 1'b1) begin errors++; $display("FAIL pre_reset_pending: got %0b want 1", bus.hit_pending); end
    do_reset();
    checks++; if ({bus.kill, bus.clash, bus.hit_pending} !== 3'b000) begin errors++; $display("FAIL reset_outputs: got %b want 000", {bus.kill, bus.clash, bus.hit_pending}); end
    checks++; if (bus.kills !== 8'd0) begin errors++; $display("FAIL reset_kills: got %0d want 0", bus.kills); end
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b1) begin errors++; $display("FAIL reset_idle: kills_seen %0d pending %0b want 0/1", k, bus.hit_pending); end
    do_reset();
  endtask

  task automatic test_direct_hit();
    int k, c, at;
    set_tip(100, 200);
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b1) begin errors++; $display("FAIL hit_first_frame: kill %0d pending %0b want 0/1", k, bus.hit_pending); end
    do_frame(k, c, at);
    checks++; if (k !== 1 || at !== 2) begin errors++; $display("FAIL hit_kill_pulse: count %0d at %0d want 1 at 2", k, at); end
    checks++; if (bus.kills !== 8'd1 || bus.hit_pending !== 1'b0) begin errors++; $display("FAIL hit_kills: kills %0d pending %0b want 1/0", bus.kills, bus.hit_pending); end
  endtask

  task automatic test_edge_miss();
    int k, c, at;
    do_round_reset();
    set_tip(110, 240);
    do_frame(k, c, at);
    do_frame(k, c, at);
    checks++; if (k !== 1 || bus.kills !== 8'd2) begin errors++; $display("FAIL edge_inclusive: kill %0d kills %0d want 1/2", k, bus.kills); end
    do_round_reset();
    set_tip(111, 200);
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b0) begin errors++; $display("FAIL edge_miss: kill %0d pending %0b want 0/0", k, bus.hit_pending); end
    set_tip(100, 180);
    do_frame(k, c, at);
    set_tip(300, 200);
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b0) begin errors++; $display("FAIL miss_returns_idle: kill %0d pending %0b want 0/0", k, bus.hit_pending); end
    set_tip(100, 200);
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b1) begin errors++; $display("FAIL miss_restart: kill %0d pending %0b want 0/1", k, bus.hit_pending); end
    do_round_reset();
  endtask

  task automatic test_clash();
    int k, c, at;
    set_tip(100, 200);
    bus.def_guard = 1'b1; bus.def_sword_y = 12'd208;
    do_frame(k, c, at);
    checks++; if (c !== 1 || k !== 0 || bus.hit_pending !== 1'b0) begin errors++; $display("FAIL clash_tol8: clash %0d kill %0d pending %0b want 1/0/0", c, k, bus.hit_pending); end
    bus.def_guard = 1'b0;
    do_frame(k, c, at);
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.kills !== 8'd2) begin errors++; $display("FAIL clash_cooldown: kill %0d kills %0d want 0/2", k, bus.kills); end
    do_round_reset();
    bus.def_guard = 1'b1; bus.def_sword_y = 12'd209;
    do_frame(k, c, at);
    checks++; if (c !== 0 || bus.hit_pending !== 1'b1) begin errors++; $display("FAIL clash_tol9: clash %0d pending %0b want 0/1", c, bus.hit_pending); end
    do_frame(k, c, at);
    checks++; if (k !== 1 || c !== 0 || bus.kills !== 8'd3) begin errors++; $display("FAIL clash_tol9_kill: kill %0d clash %0d kills %0d want 1/0/3", k, c, bus.kills); end
    do_round_reset();
    bus.def_sword_y = 12'd192;
    do_frame(k, c, at);
    checks++; if (c !== 1 || k !== 0) begin errors++; $display("FAIL clash_below: clash %0d kill %0d want 1/0", c, k); end
    bus.def_guard = 1'b0;
    do_round_reset();
  endtask

  task automatic test_cooldown();
    int k, c, at, total;
    set_tip(100, 200);
    do_frame(k, c, at);
    do_frame(k, c, at);
    checks++; if (k !== 1 || bus.kills !== 8'd4) begin errors++; $display("FAIL cd_first_kill: kill %0d kills %0d want 1/4", k, bus.kills); end
    total = 0;
    for (int f = 0; f < 40; f++) begin
      do_frame(k, c, at);
      total += k;
    end
    checks++; if (total !== 0 || bus.hit_pending !== 1'b0) begin errors++; $display("FAIL cd_hold: kills_seen %0d pending %0b want 0/0", total, bus.hit_pending); end
    bus.atk_lunge = 1'b0;
    do_frame(k, c, at);
    bus.atk_lunge = 1'b1;
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b1) begin errors++; $display("FAIL cd_rearm: kill %0d pending %0b want 0/1", k, bus.hit_pending); end
    do_frame(k, c, at);
    checks++; if (k !== 1 || bus.kills !== 8'd5) begin errors++; $display("FAIL cd_second_kill: kill %0d kills %0d want 1/5", k, bus.kills); end
    do_round_reset();
  endtask

  task automatic test_blocking();
    int k, c, at, total;
    bus.def_dead = 1'b1;
    total = 0;
    for (int f = 0; f < 3; f++) begin
      do_frame(k, c, at);
      total += k;
    end
    checks++; if (total !== 0 || bus.hit_pending !== 1'b0) begin errors++; $display("FAIL dead_block: kills_seen %0d pending %0b want 0/0", total, bus.hit_pending); end
    bus.def_dead = 1'b0;
    do_frame(k, c, at);
    do_round_reset();
    checks++; if (bus.hit_pending !== 1'b0 || bus.kills !== 8'd5) begin errors++; $display("FAIL round_reset: pending %0b kills %0d want 0/5", bus.hit_pending, bus.kills); end
    do_frame(k, c, at);
    checks++; if (k !== 0 || bus.hit_pending !== 1'b1) begin errors++; $display("FAIL round_reset_idle: kill %0d pending %0b want 0/1", k, bus.hit_pending); end
    do_round_reset();
    @(negedge clk);
    bus.frame_tick = 1'b1; round_reset = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0; round_reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.hit_pending !== 1'b0) begin errors++; $display("FAIL tick_discarded: pending %0b want 0", bus.hit_pending); end
  endtask

  task automatic test_back_to_back();
    int k, at;
    k = 0; at = -1;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) bus.frame_tick = 1'b1;
      else bus.frame_tick = 1'b0;
      if (bus.kill) begin
        k++;
        if (at < 0) at = i;
      end
    end
    checks++; if (k !== 1 || at !== 3 || bus.kills !== 8'd6) begin errors++; $display("FAIL back_to_back: count %0d at %0d kills %0d want 1 at 3 / 6", k, at, bus.kills); end
  endtask

  task automatic test_saturation();
    int total;
    do_reset();
    total = 0;
    for (int n = 0; n < 256; n++) begin
      for (int t = 0; t < 33; t++) begin
        @(negedge clk);
        if (bus.kill) total++;
        bus.frame_tick = 1'b1;
        bus.atk_lunge  = (t < 2);
      end
    end
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (5) begin
      if (bus.kill) total++;
      @(negedge clk);
    end
    checks++; if (total !== 256) begin errors++; $display("FAIL sat_pulses: got %0d want 256", total); end
    checks++; if (bus.kills !== 8'd255) begin errors++; $display("FAIL sat_kills: got %0d want 255", bus.kills); end
  endtask

  initial begin
    bus.frame_tick  = 1'b0;
    bus.atk_lunge   = 1'b1;
    bus.def_x_l     = 12'd90;
    bus.def_x_r     = 12'd110;
    bus.def_y_t     = 12'd180;
    bus.def_y_b     = 12'd240;
    bus.def_guard   = 1'b0;
    bus.def_sword_y = 12'd0;
    bus.def_dead    = 1'b0;
    set_tip(100, 200);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_direct_hit();
    test_edge_miss();
    test_clash();
    test_cooldown();
    test_blocking();
    test_back_to_back();
    test_saturation();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Upstream of the per-player death timer: decides once per video frame whether the attacker's sword tip has struck the defender.
- Emits a one-cycle `kill` pulse that drives the death timer's `active` input.
- Resolves sword clashes (parries), requires the hit to persist for several frames, and enforces a cooldown so one lunge cannot kill twice.
- One instance per attacker/defender pair.

Parameters:
- COORD_W, 12, width of all pixel coordinates (unsigned).
- CONFIRM_FRAMES, 2, consecutive overlapping frames needed before a kill (legal range 1..15).
- CLASH_TOL, 8, max vertical distance in pixels between tip_y and def_sword_y that counts as a parry.
- COOLDOWN_FRAMES, 30, minimum evaluated frames after a kill/clash before re-arming (legal range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears everything.
- frame_tick  in  1  one-cycle pulse per frame at start of vblank; coordinates are stable when it is high.
- round_reset  in  1  synchronous; clears the FSM and pipeline, preserves `kills`.
- atk_lunge  in  1  attacker's sword is extended.
- atk_tip_x, atk_tip_y  in  COORD_W each  attacker sword-tip position.
- def_x_l, def_x_r, def_y_t, def_y_b  in  COORD_W each  defender hitbox, inclusive bounds.
- def_guard  in  1  defender is holding the sword up.
- def_sword_y  in  COORD_W  defender sword height.
- def_dead  in  1  defender's death flag (from its death timer).
- kill  out  1  one-cycle pulse: hit confirmed.
- clash  out  1  one-cycle pulse: parry occurred.
- hit_pending  out  1  high while in CONFIRM.
- kills  out  8  saturating count of confirmed kills.

Behaviour:
Reset values:
- reset: all outputs 0, state IDLE, all counters 0, pipeline valid bits 0.
- round_reset: same as reset except `kills` is held.
- Priority: reset > round_reset > normal operation. A frame_tick coincident with round_reset is discarded.

Pipeline (edges E0, E1, E2):
- E0 (frame_tick high): snapshot all inputs into registers; set v1=1.
- E1: compute flags from the snapshot and register them; set v2=1.
  - overlap = lunge && x_l<=tip_x<=x_r && y_t<=tip_y<=y_b.
  - clash_c = overlap && guard && |tip_y - sword_y| <= CLASH_TOL. The difference is computed unsigned with COORD_W+1 bits.
  - An inverted box (x_l>x_r or y_t>y_b) never overlaps.
- E2: FSM evaluates (eval = v2). kill/clash are registered and therefore high during the cycle E2..E3 only.
- Latency: 2 cycles from the frame_tick edge.
- Back-to-back frame_ticks are each processed.
- kill and clash are 0 on every non-eval cycle.

FSM, on eval:
- IDLE:
  - snapshot def_dead=1 → stay.
  - clash_c → clash=1, cd_cnt=0, go COOLDOWN.
  - overlap with CONFIRM_FRAMES=1 → kill.
  - overlap otherwise → conf_cnt=1, go CONFIRM.
- CONFIRM:
  - def_dead or !overlap → conf_cnt=0, go IDLE.
  - clash_c → clash=1, go COOLDOWN.
  - overlap → conf_cnt+1; on reaching CONFIRM_FRAMES → kill.
- kill action: kill=1; kills+1 (saturates at 255); cd_cnt=0; conf_cnt=0; go COOLDOWN.
- COOLDOWN:
  - cd_cnt increments per eval, saturating at COOLDOWN_FRAMES.
  - Exit to IDLE on an eval where cd_cnt has already reached COOLDOWN_FRAMES and snapshot lunge=0. The attacker must retract before re-arming.
- Clash has priority over hit in every state.
- hit_pending = (state==CONFIRM), registered.

Test Plan:
- Reset: assert reset 3 cycles mid-CONFIRM → kill=clash=hit_pending=0, kills=0, state IDLE.
- Direct hit: box x 90..110, y 180..240; tip (100,200); lunge=1, guard=0; two frame_ticks → hit_pending=1 after the first eval; kill high exactly one cycle, 2 cycles after the second frame_tick; kills=1.
- Edge and miss:
  - tip (110,240) on two frames → kill (bounds are inclusive).
  - tip (111,200) → no overlap.
  - overlap one frame then tip (300,200) → returns to IDLE, no kill.
- Clash tolerance:
  - guard=1, sword_y=208, tip_y=200 → clash pulse, no kill, COOLDOWN.
  - sword_y=209 → no clash; kill after 2 frames.
- Cooldown:
  - after a kill, keep lunge=1 with overlap for 40 frames → no second kill.
  - drop lunge for 1 frame (≥30 evals elapsed), then overlap 2 frames → second kill, kills=2.
- Blocking and saturation:
  - def_dead=1 with overlap → no kill.
  - round_reset in CONFIRM → IDLE, kills preserved.
  - force 256 kills → kills stays 255.
